// File: rtl/clkdiv_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// clkdiv_pkg : shared timebase constants and monitor state encoding
// Revision   : 1.0
// ----------------------------------------------------------------------------
package clkdiv_pkg;

  localparam int CLK_HZ      = 50_000_000;
  localparam int P_1HZ       = 50_000_000;
  localparam int P_067HZ     = 75_000_000;
  localparam int P_05HZ_EDGE = 100_000_000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2
  } mon_state_t;

  // Lower tolerance bound, clamped so a large TOL never wraps below zero.
  function automatic int lower_bound(input int expected, input int tol);
    return (expected > tol) ? (expected - tol) : 0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tick_edge_detect.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tick_edge_detect : one-cycle edge strobe from a tick pulse or toggling level
// Revision         : 1.0
// ----------------------------------------------------------------------------
module tick_edge_detect #(
  parameter int EDGE_MODE = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_in,
  output logic tick_edge
);

  logic tick_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= tick_in;
    end
  end

  generate
    if (EDGE_MODE == 1) begin : g_both_edges
      assign tick_edge = tick_in ^ tick_q;
    end else begin : g_rise_edge
      assign tick_edge = tick_in & ~tick_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/tick_period_monitor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tick_period_monitor : measures tick-to-tick interval, checks tolerance,
//                       flags missing ticks and reports lock
// Revision            : 1.0
// ----------------------------------------------------------------------------
module tick_period_monitor
  import clkdiv_pkg::*;
#(
  parameter int CNT_W     = 27,
  parameter int EXPECTED  = 50_000_000,
  parameter int TOL       = 50_000,
  parameter int TIMEOUT   = 100_000_000,
  parameter int LOCK_N    = 4,
  parameter int EDGE_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             tick_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             in_tol,
  output logic             timeout,
  output logic             locked
);

  localparam int               LCW      = $clog2(LOCK_N + 1);
  localparam logic [CNT_W:0]   LO_BOUND = (CNT_W+1)'(lower_bound(EXPECTED, TOL));
  localparam logic [CNT_W:0]   HI_BOUND = (CNT_W+1)'(EXPECTED + TOL);
  localparam logic [CNT_W:0]   TMO      = (CNT_W+1)'(TIMEOUT);
  localparam logic [LCW-1:0]   LOCK_MAX = LCW'(LOCK_N);

  mon_state_t       state;
  mon_state_t       next_state;
  logic             tick_edge;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   period_raw;
  logic             tmo_hit;
  logic             in_range;
  logic [LCW-1:0]   lock_cnt;
  logic [LCW-1:0]   lock_next;

  logic             meas_done;
  logic             tmo_fire;
  logic             cnt_clr;
  logic             lock_clr;
  logic             lock_inc;

  tick_edge_detect #(
    .EDGE_MODE (EDGE_MODE)
  ) u_edge (
    .clk       (clk),
    .rst       (rst),
    .tick_in   (tick_in),
    .tick_edge (tick_edge)
  );

  // One bit wider than the counter so the bound compare cannot overflow.
  assign period_raw = {1'b0, cnt} + (CNT_W+1)'(1);
  assign tmo_hit    = (period_raw == TMO);
  assign in_range   = (period_raw >= LO_BOUND) && (period_raw <= HI_BOUND);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (!en) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    next_state = ARMED;
        ARMED:   if (tick_edge) next_state = MEASURE;
        MEASURE: if (!tick_edge && tmo_hit) next_state = ARMED;
        default: next_state = IDLE;
      endcase
    end
  end

  // An edge coinciding with the timeout count is a valid period, not a timeout.
  always_comb begin
    meas_done = 1'b0;
    tmo_fire  = 1'b0;
    cnt_clr   = 1'b1;
    if (en && (state == MEASURE)) begin
      meas_done = tick_edge;
      tmo_fire  = !tick_edge && tmo_hit;
      cnt_clr   = tick_edge || tmo_hit;
    end
    lock_clr = !en || tmo_fire || (meas_done && !in_range);
    lock_inc = meas_done && in_range && (lock_cnt != LOCK_MAX);
  end

  always_comb begin
    lock_next = lock_cnt;
    if (lock_clr) begin
      lock_next = '0;
    end else if (lock_inc) begin
      lock_next = lock_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      in_tol       <= 1'b0;
      timeout      <= 1'b0;
      lock_cnt     <= '0;
      locked       <= 1'b0;
    end else begin
      cnt          <= cnt_clr ? '0 : cnt + 1'b1;
      period_valid <= meas_done;
      timeout      <= tmo_fire;
      lock_cnt     <= lock_next;
      locked       <= (lock_next == LOCK_MAX);
      if (meas_done) begin
        period <= period_raw[CNT_W-1:0];
        in_tol <= in_range;
      end
    end
  end

endmodule
`default_nettype wire
